msm_input_loader: RTL
=====================

// Module: msm_input_loader
// PURPOSE
//  Upstream feeder for msm_arr. Takes a 64-bit AXI-Stream of (x,y,z,k) point/scalar records,
//  assembles each field into its full width, and writes it into the P_arr_x/y/z and K_arr
//  memories through their port 1. Once all records are loaded, it starts msm_arr with the
//  ap_ctrl_hs handshake, waits for ap_done, then reports completion.
// PARAMETERS
//  EC_BASE_FIELD_WIDTH    377  width of x/y/z coordinates
//  EC_SCALAR_FIELD_WIDTH  256  width of scalar k
//  ADDR_WIDTH             4    memory address width
//  MEM_SIZE               16   max points per run
//  IN_WIDTH               64   stream word width; NB=ceil(377/64)=6 words/coord, NS=ceil(256/64)=4 words/scalar
// PORTS
//  ap_clk             in   1            clock
//  ap_rst_n           in   1            async active-low reset
//  cfg_start          in   1            1-cycle pulse; starts a load run (ignored while busy)
//  cfg_num_points     in   ADDR_WIDTH+1 number of records N, sampled at cfg_start
//  s_tdata            in   IN_WIDTH     stream data
//  s_tvalid           in   1            stream valid
//  s_tready           out  1            stream ready
//  s_tlast            in   1            marks final word of final record
//  P_arr_{x,y,z}_address1 out ADDR_WIDTH  write address (record index)
//  P_arr_{x,y,z}_ce1/we1  out 1           write strobe, 1 cycle
//  P_arr_{x,y,z}_d1       out EC_BASE_FIELD_WIDTH write data
//  K_arr_address1/ce1/we1/d1  out  ADDR_WIDTH/1/1/EC_SCALAR_FIELD_WIDTH   scalar write
//  msm_ap_start       out  1            to msm_arr ap_start
//  msm_ap_ready       in   1            from msm_arr ap_ready
//  msm_ap_done        in   1            from msm_arr ap_done
//  busy               out  1            high from accepted cfg_start until done pulse
//  done               out  1            1-cycle completion pulse
//  err                out  1            sticky framing/config error; cleared by next accepted cfg_start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, index=0. Async assert; deassert synchronous to ap_clk.
//  Record format: X[NB] Y[NB] Z[NB] K[NS] words, 22 words/record. Least-significant word first.
//   Bits of the last word above the field width are discarded.
//  FSM: IDLE -> (cfg_start) LD_X -> LD_Y -> LD_Z -> LD_K -> (idx<N-1) LD_X | (idx==N-1) KICK
//   -> WAIT_DONE -> FIN -> IDLE.
//  A word is accepted when s_tvalid&&s_tready. s_tready=1 only in LD_* states, so there are no bubbles.
//  On the final accepted word of a field, d1 <= {word,acc} truncated, and address1 <= idx.
//   In the following cycle, ce1=we1=1 for exactly one cycle on that array only.
//  idx increments after the K field completes. Writes never stall the stream.
//  KICK: msm_ap_start=1 from the cycle after the last K write, held until msm_ap_ready=1 is sampled.
//   It drops the cycle after. msm_ap_done may coincide with ready; it is latched either way.
//  WAIT_DONE: wait for msm_ap_done (or the latched done). FIN: done=1 for 1 cycle, busy=0 next cycle.
//  Errors:
//   cfg_num_points==0 or >MEM_SIZE: err=1, no stream consumed, no MSM start, FIN next cycle.
//   s_tlast on any word except the final word of record N-1: err=1, no MSM start. FIN, rest of stream left unread.
//   s_tlast missing on the final word: err=1, but the MSM is still started normally.
//  cfg_start while busy: ignored. cfg_num_points is only sampled at an accepted cfg_start.
//  Reset mid-run: immediate abort. Pending writes are dropped, msm_ap_start goes low, state returns to IDLE.
// TESTING
//  N=1, 22 words 0x1..0x16, tlast on the last word -> x_d1[63:0]=1, x_d1[376:320]=6[56:0],
//   K_d1[255:192]=0x16, all at addr 0. Then one start handshake and done after msm_ap_done.
//  N=16, random tvalid gaps -> 64 writes total (16 per array) at addr 0..15 in order.
//   msm_ap_start rises only after the addr-15 K write.
//  cfg_num_points=0, and separately 17 -> err=1, done after 2 cycles, s_tready never 1, msm_ap_start never 1.
//  N=2, tlast on word 22 -> err=1, msm_ap_start stays 0, done pulses, and 22nd-word K write still issues.
//  msm_ap_ready delayed 5 cycles, and ready/done in the same cycle -> start held exactly until ready.
//   done pulses exactly once.
//  ap_rst_n low during LD_Y of record 3 -> all outputs 0 immediately.
//   A new N=1 run afterwards writes at addr 0.

Source files
------------

// File: rtl/msm_input_loader_if.sv
// Stream, memory-write and msm_arr control bundle for msm_input_loader.
// slave is the loader's view; master is the environment (stream source, memories, msm_arr).
interface msm_input_loader_if #(
  parameter int IN_WIDTH              = 64,
  parameter int ADDR_WIDTH            = 4,
  parameter int EC_BASE_FIELD_WIDTH   = 377,
  parameter int EC_SCALAR_FIELD_WIDTH = 256
);
  logic [IN_WIDTH-1:0]              s_tdata;
  logic                             s_tvalid;
  logic                             s_tready;
  logic                             s_tlast;

  logic [ADDR_WIDTH-1:0]            P_arr_x_address1;
  logic                             P_arr_x_ce1;
  logic                             P_arr_x_we1;
  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_d1;
  logic [ADDR_WIDTH-1:0]            P_arr_y_address1;
  logic                             P_arr_y_ce1;
  logic                             P_arr_y_we1;
  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_d1;
  logic [ADDR_WIDTH-1:0]            P_arr_z_address1;
  logic                             P_arr_z_ce1;
  logic                             P_arr_z_we1;
  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_d1;
  logic [ADDR_WIDTH-1:0]            K_arr_address1;
  logic                             K_arr_ce1;
  logic                             K_arr_we1;
  logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_d1;

  logic                             msm_ap_start;
  logic                             msm_ap_ready;
  logic                             msm_ap_done;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output P_arr_x_address1, P_arr_x_ce1, P_arr_x_we1, P_arr_x_d1,
    output P_arr_y_address1, P_arr_y_ce1, P_arr_y_we1, P_arr_y_d1,
    output P_arr_z_address1, P_arr_z_ce1, P_arr_z_we1, P_arr_z_d1,
    output K_arr_address1, K_arr_ce1, K_arr_we1, K_arr_d1,
    output msm_ap_start,
    input  msm_ap_ready, msm_ap_done
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  P_arr_x_address1, P_arr_x_ce1, P_arr_x_we1, P_arr_x_d1,
    input  P_arr_y_address1, P_arr_y_ce1, P_arr_y_we1, P_arr_y_d1,
    input  P_arr_z_address1, P_arr_z_ce1, P_arr_z_we1, P_arr_z_d1,
    input  K_arr_address1, K_arr_ce1, K_arr_we1, K_arr_d1,
    input  msm_ap_start,
    output msm_ap_ready, msm_ap_done
  );
endinterface

// File: rtl/msm_input_loader.sv
// Loads (x,y,z,k) records from a 64-bit stream into the msm_arr memories,
// then runs msm_arr once through its ap_ctrl_hs handshake.
module msm_input_loader #(
  parameter int EC_BASE_FIELD_WIDTH   = 377,
  parameter int EC_SCALAR_FIELD_WIDTH = 256,
  parameter int ADDR_WIDTH            = 4,
  parameter int MEM_SIZE              = 16,
  parameter int IN_WIDTH              = 64
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH:0]   cfg_num_points,
  msm_input_loader_if.slave     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int NB    = (EC_BASE_FIELD_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int NS    = (EC_SCALAR_FIELD_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  // Shift register sized for the longer (base) field; the scalar sits at its top end.
  localparam int ACC_W = NB * IN_WIDTH;
  localparam int K_LSB = ACC_W - NS * IN_WIDTH;
  localparam int WC_W  = $clog2(NB);
  localparam int NW    = ADDR_WIDTH + 1;
  localparam logic [WC_W-1:0] NB_LAST = WC_W'(NB - 1);
  localparam logic [WC_W-1:0] NS_LAST = WC_W'(NS - 1);
  localparam logic [NW-1:0]   MAX_N   = NW'(MEM_SIZE);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LD_X      = 3'd1;
  localparam logic [2:0] S_LD_Y      = 3'd2;
  localparam logic [2:0] S_LD_Z      = 3'd3;
  localparam logic [2:0] S_LD_K      = 3'd4;
  localparam logic [2:0] S_KICK      = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_FIN       = 3'd7;

  logic [2:0]                       state;
  logic [ADDR_WIDTH-1:0]            idx;
  logic [NW-1:0]                    num;
  logic [WC_W-1:0]                  wcnt;
  logic [ACC_W-IN_WIDTH-1:0]        acc;
  logic [ACC_W-1:0]                 word_p0;
  logic                             ld, beat, field_end, last_rec, final_word, cfg_ok;
  logic [ADDR_WIDTH-1:0]            addr_p1;
  logic                             wr_x_p1, wr_y_p1, wr_z_p1, wr_k_p1;
  logic [EC_BASE_FIELD_WIDTH-1:0]   base_d_p1;
  logic [EC_SCALAR_FIELD_WIDTH-1:0] k_d_p1;
  logic                             start_r, done_seen;

  // Stage p0: incoming word joined with the words already collected for this field
  always_comb begin
    ld         = (state == S_LD_X) || (state == S_LD_Y) || (state == S_LD_Z) || (state == S_LD_K);
    beat       = ld && bus.s_tvalid;
    field_end  = beat && (wcnt == ((state == S_LD_K) ? NS_LAST : NB_LAST));
    last_rec   = ({1'b0, idx} == (num - 1'b1));
    final_word = field_end && (state == S_LD_K) && last_rec;
    cfg_ok     = (cfg_num_points != '0) && (cfg_num_points <= MAX_N);
    word_p0    = {bus.s_tdata, acc};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      num       <= '0;
      wcnt      <= '0;
      acc       <= '0;
      addr_p1   <= '0;
      wr_x_p1   <= 1'b0;
      wr_y_p1   <= 1'b0;
      wr_z_p1   <= 1'b0;
      wr_k_p1   <= 1'b0;
      base_d_p1 <= '0;
      k_d_p1    <= '0;
      start_r   <= 1'b0;
      done_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_x_p1 <= 1'b0;
      wr_y_p1 <= 1'b0;
      wr_z_p1 <= 1'b0;
      wr_k_p1 <= 1'b0;
      done    <= (state == S_FIN);
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy still covers the done cycle, so a start there is ignored
          if (cfg_start && !busy) begin
            busy      <= 1'b1;
            err       <= !cfg_ok;
            num       <= cfg_num_points;
            idx       <= '0;
            wcnt      <= '0;
            done_seen <= 1'b0;
            state     <= cfg_ok ? S_LD_X : S_FIN;
          end
        end
        S_LD_X, S_LD_Y, S_LD_Z, S_LD_K: begin
          if (beat) begin
            acc  <= word_p0[ACC_W-1:IN_WIDTH];
            wcnt <= field_end ? '0 : wcnt + 1'b1;
            // Stage p1: field complete, present it on port 1 for one strobe cycle
            if (field_end) begin
              addr_p1 <= idx;
              case (state)
                S_LD_X: begin base_d_p1 <= word_p0[EC_BASE_FIELD_WIDTH-1:0]; wr_x_p1 <= 1'b1; state <= S_LD_Y; end
                S_LD_Y: begin base_d_p1 <= word_p0[EC_BASE_FIELD_WIDTH-1:0]; wr_y_p1 <= 1'b1; state <= S_LD_Z; end
                S_LD_Z: begin base_d_p1 <= word_p0[EC_BASE_FIELD_WIDTH-1:0]; wr_z_p1 <= 1'b1; state <= S_LD_K; end
                default: begin
                  k_d_p1  <= word_p0[K_LSB +: EC_SCALAR_FIELD_WIDTH];
                  wr_k_p1 <= 1'b1;
                  if (last_rec) state <= S_KICK;
                  else begin
                    idx   <= idx + 1'b1;
                    state <= S_LD_X;
                  end
                end
              endcase
            end
            // An early tlast aborts the run; the word itself is still written
            if (bus.s_tlast && !final_word) begin
              err   <= 1'b1;
              state <= S_FIN;
            end else if (final_word && !bus.s_tlast) begin
              err <= 1'b1;
            end
          end
        end
        S_KICK: begin
          if (!start_r) start_r <= 1'b1;
          else if (bus.msm_ap_ready) begin
            start_r <= 1'b0;
            state   <= S_WAIT_DONE;
          end
          if (start_r && bus.msm_ap_done) done_seen <= 1'b1;
        end
        S_WAIT_DONE: if (bus.msm_ap_done || done_seen) state <= S_FIN;
        S_FIN:       state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_tready         = ld;
  assign bus.P_arr_x_address1 = addr_p1;
  assign bus.P_arr_x_ce1      = wr_x_p1;
  assign bus.P_arr_x_we1      = wr_x_p1;
  assign bus.P_arr_x_d1       = base_d_p1;
  assign bus.P_arr_y_address1 = addr_p1;
  assign bus.P_arr_y_ce1      = wr_y_p1;
  assign bus.P_arr_y_we1      = wr_y_p1;
  assign bus.P_arr_y_d1       = base_d_p1;
  assign bus.P_arr_z_address1 = addr_p1;
  assign bus.P_arr_z_ce1      = wr_z_p1;
  assign bus.P_arr_z_we1      = wr_z_p1;
  assign bus.P_arr_z_d1       = base_d_p1;
  assign bus.K_arr_address1   = addr_p1;
  assign bus.K_arr_ce1        = wr_k_p1;
  assign bus.K_arr_we1        = wr_k_p1;
  assign bus.K_arr_d1         = k_d_p1;
  assign bus.msm_ap_start     = start_r;
endmodule
